// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : menu_pkg
//  Purpose  : Shared widths, FSM state encoding and named menu segments for
//             the menu ROM streamer.
//  Revision : 1.0 - initial release
// ============================================================================
package menu_pkg;

  // ROM address width and segment length width
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 10;

  // Streamer FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Named segments of the menu ROM
  localparam int MENU_BASE  = 0;
  localparam int MENU_LEN   = 122;  // complete menu text
  localparam int TITLE_BASE = 0;
  localparam int TITLE_LEN  = 31;   // first line including CR LF

endpackage
`default_nettype wire

// File: rtl/menu_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : menu_streamer_if
//  Purpose  : Byte stream valid/ready handshake between the menu streamer
//             (master) and the UART transmitter (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface menu_streamer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface
`default_nettype wire

// File: rtl/menu_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : menu_streamer
//  Purpose  : Reads a contiguous segment of the menu ROM and streams it one
//             byte at a time to the UART transmitter. The ROM has a one-cycle
//             registered read, so every byte goes FETCH -> LOAD -> SEND.
//  Revision : 1.0 - initial release
// ============================================================================
module menu_streamer
  import menu_pkg::*;
#(
  parameter int ADDR_W = menu_pkg::ADDR_W,
  parameter int LEN_W  = menu_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] seg_addr,
  input  logic [LEN_W-1:0]  seg_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_dout,
  menu_streamer_if.master   tx,
  output logic              busy,
  output logic              done
);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr,  w_addr_next;
  logic [LEN_W-1:0]  r_count, w_count_next;
  logic [7:0]        r_data,  w_data_next;
  logic              r_valid, w_valid_next;
  logic              r_busy,  w_busy_next;
  logic              r_done,  w_done_next;

  // Register FSM state together with every output so no input reaches an output combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_count <= w_count_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state and next-output decode; abort overrides everything outside IDLE
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_count_next = r_count;
    w_data_next  = r_data;
    w_valid_next = r_valid;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    if (abort && (r_state != IDLE)) begin
      // A handshake coinciding with abort is deliberately not accounted for
      w_state_next = IDLE;
      w_valid_next = 1'b0;
      w_busy_next  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            w_addr_next  = seg_addr;
            w_count_next = seg_len;
            w_busy_next  = 1'b1;
            w_state_next = (seg_len == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          // ROM samples rom_addr on this edge
          w_state_next = LOAD;
        end
        LOAD: begin
          w_data_next  = rom_dout;
          w_valid_next = 1'b1;
          w_state_next = SEND;
        end
        SEND: begin
          if (tx.tx_ready) begin
            w_valid_next = 1'b0;
            w_addr_next  = r_addr + ADDR_W'(1);  // wraps at the top of the ROM
            w_count_next = r_count - LEN_W'(1);
            w_state_next = (r_count == LEN_W'(1)) ? DONE : FETCH;
          end
        end
        DONE: begin
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_state_next = IDLE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign rom_addr    = r_addr;
  assign tx.tx_data  = r_data;
  assign tx.tx_valid = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_menu_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_menu_streamer
//  Purpose  : Self-checking bench for menu_streamer with a behavioural ROM
//             and a byte scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_menu_streamer;
  import menu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] seg_addr;
  logic [LEN_W-1:0]  seg_len;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_dout;
  logic              busy;
  logic              done;

  menu_streamer_if u_if ();

  menu_streamer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .seg_addr (seg_addr),
    .seg_len  (seg_len),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .tx       (u_if),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Behavioural menu ROM with one-cycle registered read
  logic [7:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]        exp_q [$];
  logic [7:0]        rx_q  [$];
  logic [ADDR_W-1:0] addr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   e0, done_cnt, done_cyc, busy_cycles, unstable, first_valid;
  logic busy_at_done, post_valid, post_busy;
  bit   timed_out;

  // Issue a start and push the bytes the ROM should yield
  task automatic start_seg(input int addr, input int len);
    seg_addr = ADDR_W'(addr);
    seg_len  = LEN_W'(len);
    start    = 1'b1;
    for (int i = 0; i < len; i++) exp_q.push_back(rom[(addr + i) % (1 << ADDR_W)]);
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  // Observe the stream at negedges, drive tx_ready, optional late start / abort
  task automatic collect(input int max_cyc, input int stall, input int inject_at, input int abort_after);
    int   tail, scnt, abort_iter;
    logic pv;
    logic [7:0] held;
    bit   aborted;
    rx_q.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; busy_cycles = 0; unstable = 0; first_valid = -1;
    busy_at_done = 1'b1; post_valid = 1'b1; post_busy = 1'b1; timed_out = 1'b1;
    tail = -1; scnt = 0; pv = 1'b0; held = '0; aborted = 1'b0; abort_iter = -10;
    for (int iter = 0; iter < max_cyc; iter++) begin
      if (u_if.tx_valid) begin
        if (pv && (u_if.tx_data !== held)) unstable++;
        held = u_if.tx_data;
        if (first_valid < 0) first_valid = cyc;
      end
      pv = u_if.tx_valid;
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++; done_cyc = cyc; busy_at_done = busy;
        if (tail < 0) tail = 3;
      end
      if (aborted && iter == abort_iter + 1) begin
        post_valid = u_if.tx_valid; post_busy = busy;
      end
      start = (iter == inject_at);
      if (start) begin seg_addr = ADDR_W'(70); seg_len = LEN_W'(6); end
      abort = 1'b0;
      if (abort_after > 0 && !aborted && rx_q.size() == abort_after) begin
        abort = 1'b1; aborted = 1'b1; abort_iter = iter; tail = 4;
      end
      if (stall == 0) u_if.tx_ready = 1'b1;
      else if (u_if.tx_valid && scnt >= stall) u_if.tx_ready = 1'b1;
      else begin
        u_if.tx_ready = 1'b0;
        if (u_if.tx_valid) scnt++;
      end
      if (u_if.tx_valid && u_if.tx_ready) begin
        rx_q.push_back(u_if.tx_data); addr_q.push_back(rom_addr); scnt = 0;
      end
      @(negedge clk);
      if (tail > 0) begin
        tail--;
        if (tail == 0) begin timed_out = 1'b0; break; end
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seg_addr = '0; seg_len = '0; u_if.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rom_addr !== '0)     begin errors++; $display("FAIL reset rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (u_if.tx_data !== '0) begin errors++; $display("FAIL reset tx_data: got %0d expected 0", u_if.tx_data); end
    checks++; if (u_if.tx_valid !== 0) begin errors++; $display("FAIL reset tx_valid: got %0b expected 0", u_if.tx_valid); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset busy/done: got %b expected 00", {busy, done}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_menu();
    logic [7:0] got, want;
    int idx = 0;
    start_seg(MENU_BASE, MENU_LEN);
    collect(600, 0, -1, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL full_menu timeout: got no done expected done"); end
    checks++; if (rx_q.size() != MENU_LEN) begin errors++; $display("FAIL full_menu count: got %0d expected %0d", rx_q.size(), MENU_LEN); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL full_menu byte %0d: got %0d expected %0d", idx, got, want); end
      idx++;
    end
    exp_q.delete();
    checks++; if (first_valid - e0 != 2) begin errors++; $display("FAIL full_menu first_valid: got %0d expected 2", first_valid - e0); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_menu done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc - e0 != 367) begin errors++; $display("FAIL full_menu done_latency: got %0d expected 367", done_cyc - e0); end
    checks++; if (busy_cycles != 367) begin errors++; $display("FAIL full_menu busy_cycles: got %0d expected 367", busy_cycles); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL full_menu busy_at_done: got %0b expected 0", busy_at_done); end
  endtask

  task automatic test_backpressure();
    logic [7:0] got, want;
    int idx = 0;
    start_seg(0, 3);
    collect(200, 5, -1, 0);
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL backpressure count: got %0d expected 3", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL backpressure byte %0d: got %0d expected %0d", idx, got, want); end
      idx++;
    end
    exp_q.delete();
    checks++; if (unstable != 0) begin errors++; $display("FAIL backpressure hold: got %0d changes expected 0", unstable); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL backpressure done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_zero_length();
    start_seg(0, 0);
    collect(20, 0, -1, 0);
    checks++; if (first_valid != -1) begin errors++; $display("FAIL zero_len tx_valid: got rise at %0d expected none", first_valid); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_len done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc - e0 != 1) begin errors++; $display("FAIL zero_len done_latency: got %0d expected 1", done_cyc - e0); end
    checks++; if (busy_cycles != 1) begin errors++; $display("FAIL zero_len busy_cycles: got %0d expected 1", busy_cycles); end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] got, want;
    int idx = 0;
    start_seg(0, 4);
    collect(100, 0, 4, 0);
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL busy_start count: got %0d expected 4", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL busy_start byte %0d: got %0d expected %0d", idx, got, want); end
      idx++;
    end
    exp_q.delete();
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc - e0 != 13) begin errors++; $display("FAIL busy_start done_latency: got %0d expected 13", done_cyc - e0); end
  endtask

  task automatic test_abort();
    logic [7:0] got, want;
    int idx = 0;
    start_seg(0, 10);
    collect(100, 0, -1, 2);
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL abort count: got %0d expected 2", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL abort byte %0d: got %0d expected %0d", idx, got, want); end
      idx++;
    end
    exp_q.delete();
    checks++; if ({post_valid, post_busy} !== 2'b00) begin errors++; $display("FAIL abort valid/busy: got %b expected 00", {post_valid, post_busy}); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort done_count: got %0d expected 0", done_cnt); end
    // Following segment: "UNIS24"
    idx = 0;
    start_seg(70, 6);
    collect(100, 0, -1, 0);
    checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL after_abort count: got %0d expected 6", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL after_abort byte %0d: got %0d expected %0d", idx, got, want); end
      idx++;
    end
    exp_q.delete();
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL after_abort done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_wrap_reset();
    logic [7:0] got, want;
    int idx = 0;
    bit seen = 1'b0;
    start_seg((1 << ADDR_W) - 1, 2);
    collect(50, 0, -1, 0);
    checks++; if (addr_q.size() != 2) begin errors++; $display("FAIL wrap count: got %0d expected 2", addr_q.size()); end
    else begin
      checks++; if (addr_q[0] !== ADDR_W'((1 << ADDR_W) - 1)) begin errors++; $display("FAIL wrap addr0: got %0d expected %0d", addr_q[0], (1 << ADDR_W) - 1); end
      checks++; if (addr_q[1] !== '0) begin errors++; $display("FAIL wrap addr1: got %0d expected 0", addr_q[1]); end
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL wrap byte %0d: got %0d expected %0d", idx, got, want); end
      idx++;
    end
    exp_q.delete();
    // Reset in the middle of SEND, with the UART holding off
    u_if.tx_ready = 1'b0;
    start_seg(0, 5);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (u_if.tx_valid) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL reset_mid reach_send: got no tx_valid expected tx_valid"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({u_if.tx_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_mid valid/busy/done: got %b expected 000", {u_if.tx_valid, busy, done}); end
    checks++; if (rom_addr !== '0 || u_if.tx_data !== '0) begin errors++; $display("FAIL reset_mid addr/data: got %0d/%0d expected 0/0", rom_addr, u_if.tx_data); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // FSM must be back in IDLE: a fresh one-byte segment works normally
    start_seg(70, 1);
    collect(30, 0, -1, 0);
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL reset_mid restart count: got %0d expected 1", rx_q.size()); end
    else begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL reset_mid restart byte: got %0d expected %0d", got, want); end
    end
    exp_q.delete();
    checks++; if (done_cnt != 1 || done_cyc - e0 != 4) begin errors++; $display("FAIL reset_mid restart done: got %0d at %0d expected 1 at 4", done_cnt, done_cyc - e0); end
  endtask

  initial begin
    logic [7:0] s_soy [4];
    logic [7:0] s_unis[6];
    s_soy  = '{8'd83, 8'd111, 8'd121, 8'd32};
    s_unis = '{8'd85, 8'd78, 8'd73, 8'd83, 8'd50, 8'd52};
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 4; i++) rom[i] = s_soy[i];
    for (int i = 0; i < 6; i++) rom[70 + i] = s_unis[i];
    rom[TITLE_LEN - 2] = 8'd13; rom[TITLE_LEN - 1] = 8'd10;
    rom[MENU_LEN - 2]  = 8'd13; rom[MENU_LEN - 1]  = 8'd10;

    test_reset();
    test_full_menu();
    test_backpressure();
    test_zero_length();
    test_start_while_busy();
    test_abort();
    test_wrap_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/menu_streamer.md
Name: menu_streamer

Overview:
- Sequencer that reads a contiguous segment of the 1 KB menu ROM and streams it byte-by-byte to the UART transmitter over a valid/ready handshake.
- Sits between the top-level command logic, which issues start/abort, and the `menu_rom` + UART TX pair.
- Owns the ROM address bus exclusively and accounts for the ROM's 1-cycle registered read latency.

Parameters:
- ADDR_W, 10, ROM address width; address arithmetic is modulo 2^ADDR_W.
- LEN_W, 10, width of the segment length input.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to stream a segment; sampled only in IDLE
- abort  in  1  terminate the current stream; takes priority over every other event
- seg_addr  in  ADDR_W  first ROM address of segment, latched on accepted start
- seg_len  in  LEN_W  number of bytes to send, latched on accepted start
- rom_addr  out  ADDR_W  registered address to `menu_rom`
- rom_dout  in  8  byte from `menu_rom`, valid one clock after rom_addr is sampled
- tx_data  out  8  byte presented to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte when tx_valid && tx_ready at a rising edge
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse after the last byte of a non-aborted segment is accepted

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE
  - rom_addr=0, tx_data=0, tx_valid=0, busy=0, done=0
  - internal remaining-count=0
- State IDLE:
  - start=1 and abort=0 → rom_addr<=seg_addr, count<=seg_len, busy<=1.
  - If seg_len==0 → state<=DONE and no byte is sent; otherwise state<=FETCH.
- State FETCH (1 cycle): ROM samples rom_addr; state<=LOAD.
- State LOAD (1 cycle): tx_data<=rom_dout, tx_valid<=1, state<=SEND.
- State SEND:
  - Hold tx_valid=1 and tx_data stable until tx_ready.
  - On handshake: tx_valid<=0, rom_addr<=rom_addr+1 (wraps 2^ADDR_W-1→0), count<=count-1.
  - If count==1 → state<=DONE, else state<=FETCH.
- State DONE (1 cycle): done=1, busy<=0, state<=IDLE.
- Timing:
  - First tx_valid is high after the 3rd rising edge following the start sample (E0 start, E1 FETCH, E2 LOAD).
  - With tx_ready tied high, the pipeline sends one byte per 3 cycles; an N-byte segment asserts done 3N+1 cycles after the start sample.
- Outputs done, busy and tx_valid are registered; no combinational path from inputs to outputs.
- start while busy is ignored and has no side effects; start and abort together in IDLE → ignored.
- abort in any non-IDLE state:
  - Next edge: tx_valid<=0, busy<=0, state<=IDLE, no done pulse.
  - A handshake in the same cycle as abort counts as accepted by the UART, but the streamer does not report it.
- Reset asserted mid-stream → immediate return to reset values; the UART may receive a truncated segment.
- seg_len > 2^ADDR_W is legal: addresses wrap and repeat.

Decomposition:
- Shared package `menu_pkg`:
  - ADDR_W and LEN_W constants
  - state enum {IDLE, FETCH, LOAD, SEND, DONE}
  - named segment constants: MENU_BASE=0, MENU_LEN=122 for the full menu; TITLE_BASE=0, TITLE_LEN=31 for the first line including CR LF
- No sub-module: a single FSM plus address/count registers. `menu_rom` is instantiated alongside at the parent level.

Test Plan:
- Full menu, tx_ready=1: start with seg_addr=0, seg_len=122 → bytes 83,111,121,32,… in order, last two 13,10; 122 handshakes; done pulse exactly 367 cycles after start; busy falls with done.
- Backpressure: seg_addr=0, seg_len=3, tx_ready low 5 cycles per byte → tx_data held stable while valid, sequence 83,111,121, one done pulse.
- Zero length: seg_len=0 → tx_valid never rises; done pulses 1 cycle after start; busy high exactly 1 cycle.
- Start while busy: second start (seg_addr=70) during a seg_addr=0, seg_len=4 stream → ignored; output 83,111,121,32 only, one done.
- Abort mid-stream after 2nd handshake of seg_len=10 → tx_valid=0 and busy=0 on next edge, no done; a following start with seg_addr=70, seg_len=6 streams 85,78,73,83,50,52 ("UNIS24").
- Wrap and reset: seg_addr=1023, seg_len=2 → rom_addr sequence 1023 then 0; rst_n pulsed low mid-SEND → all outputs 0 asynchronously, FSM in IDLE.
